p2p_tx_arbiter: RTL and testbench

Packet-atomic, two-input round-robin arbiter that shares one CMAC TX AXI4-Stream port between two sources: the adapter TX path (source 0) and the hairpin/loopback return path (source 1). One instance sits in front of each CMAC TX interface of the p2p box, clocked in the 322 MHz CMAC domain. Per-source enables come from the box's AXI-lite register block; they let software block or steer traffic without ever truncating a packet.

---
 rtl/p2p_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_p2p_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2p_tx_arbiter.sv
// rtl/p2p_tx_arbiter.sv - packet-atomic two-source round-robin arbiter for one CMAC TX stream
// Optional per-source packet counters are enabled by defining P2P_TX_ARB_STATS_EN.
module p2p_tx_arbiter #(
   parameter int DATA_W = 512,
   parameter int KEEP_W = DATA_W / 8
) (
   input  logic              cmac_clk,
   input  logic              mod_rstn,
   input  logic              s0_axis_tvalid,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic [KEEP_W-1:0] s0_axis_tkeep,
   input  logic              s0_axis_tlast,
   input  logic              s0_axis_tuser_err,
   output logic              s0_axis_tready,
   input  logic              s1_axis_tvalid,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic [KEEP_W-1:0] s1_axis_tkeep,
   input  logic              s1_axis_tlast,
   input  logic              s1_axis_tuser_err,
   output logic              s1_axis_tready,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [KEEP_W-1:0] m_axis_tkeep,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser_err,
   input  logic              m_axis_tready,
   input  logic [1:0]        src_en,
   output logic [1:0]        grant
`ifdef P2P_TX_ARB_STATS_EN
   ,
   output logic [31:0]       pkt_cnt0,
   output logic [31:0]       pkt_cnt1,
   input  logic              cnt_clr
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_owner_q, last_owner_d;
   logic [1:0]  grant_q;
   logic        elig0, elig1;
   logic        done0, done1;

   assign elig0 = s0_axis_tvalid & src_en[0];
   assign elig1 = s1_axis_tvalid & src_en[1];
   assign done0 = (state_q == OWN0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
   assign done1 = (state_q == OWN1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;

   always_comb begin
      state_d           = state_q;
      last_owner_d      = last_owner_q;
      m_axis_tvalid     = 1'b0;
      m_axis_tdata      = '0;
      m_axis_tkeep      = '0;
      m_axis_tlast      = 1'b0;
      m_axis_tuser_err  = 1'b0;
      s0_axis_tready    = 1'b0;
      s1_axis_tready    = 1'b0;
      case (state_q)
         IDLE: begin
            // On contention the source that did not own the link last time wins.
            if (elig0 && (!elig1 || last_owner_q)) begin
               state_d      = OWN0;
               last_owner_d = 1'b0;
            end else if (elig1) begin
               state_d      = OWN1;
               last_owner_d = 1'b1;
            end
         end
         OWN0: begin
            m_axis_tvalid    = s0_axis_tvalid;
            m_axis_tdata     = s0_axis_tdata;
            m_axis_tkeep     = s0_axis_tkeep;
            m_axis_tlast     = s0_axis_tlast;
            m_axis_tuser_err = s0_axis_tuser_err;
            s0_axis_tready   = m_axis_tready;
            if (done0) state_d = IDLE;
         end
         OWN1: begin
            m_axis_tvalid    = s1_axis_tvalid;
            m_axis_tdata     = s1_axis_tdata;
            m_axis_tkeep     = s1_axis_tkeep;
            m_axis_tlast     = s1_axis_tlast;
            m_axis_tuser_err = s1_axis_tuser_err;
            s1_axis_tready   = m_axis_tready;
            if (done1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cmac_clk or negedge mod_rstn) begin
      if (!mod_rstn) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         grant_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         grant_q      <= {state_d == OWN1, state_d == OWN0};
      end
   end

   assign grant = grant_q;

`ifdef P2P_TX_ARB_STATS_EN
   logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [31:0] pkt_cnt1_q, pkt_cnt1_d;

   // Clear takes priority over a packet completing in the same cycle.
   always_comb begin
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      if (cnt_clr) begin
         pkt_cnt0_d = '0;
         pkt_cnt1_d = '0;
      end else begin
         if (done0) pkt_cnt0_d = pkt_cnt0_q + 32'd1;
         if (done1) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
      end
   end

   always_ff @(posedge cmac_clk or negedge mod_rstn) begin
      if (!mod_rstn) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_p2p_tx_arbiter.sv
// tb/tb_p2p_tx_arbiter.sv - directed scoreboard bench for p2p_tx_arbiter
module tb_p2p_tx_arbiter;

   localparam int DATA_W = 512;
   localparam int KEEP_W = 64;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic              err;
      logic              src;
   } beat_t;

   logic              cmac_clk = 1'b0;
   logic              mod_rstn;
   logic              s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser_err, s0_axis_tready;
   logic [DATA_W-1:0] s0_axis_tdata;
   logic [KEEP_W-1:0] s0_axis_tkeep;
   logic              s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser_err, s1_axis_tready;
   logic [DATA_W-1:0] s1_axis_tdata;
   logic [KEEP_W-1:0] s1_axis_tkeep;
   logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser_err, m_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic [KEEP_W-1:0] m_axis_tkeep;
   logic [1:0]        src_en;
   logic [1:0]        grant;
`ifdef P2P_TX_ARB_STATS_EN
   logic [31:0]       pkt_cnt0, pkt_cnt1;
   logic              cnt_clr;
   logic [31:0]       cnt0_m, cnt1_m;
`endif

   beat_t q0[$];
   beat_t q1[$];
   beat_t expq[$];
   int    checks   = 0;
   int    failures = 0;
   logic  smp_valid;
   logic  in_pkt = 1'b0;

   always #5 cmac_clk = ~cmac_clk;

   p2p_tx_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
      .cmac_clk          (cmac_clk),
      .mod_rstn          (mod_rstn),
      .s0_axis_tvalid    (s0_axis_tvalid),
      .s0_axis_tdata     (s0_axis_tdata),
      .s0_axis_tkeep     (s0_axis_tkeep),
      .s0_axis_tlast     (s0_axis_tlast),
      .s0_axis_tuser_err (s0_axis_tuser_err),
      .s0_axis_tready    (s0_axis_tready),
      .s1_axis_tvalid    (s1_axis_tvalid),
      .s1_axis_tdata     (s1_axis_tdata),
      .s1_axis_tkeep     (s1_axis_tkeep),
      .s1_axis_tlast     (s1_axis_tlast),
      .s1_axis_tuser_err (s1_axis_tuser_err),
      .s1_axis_tready    (s1_axis_tready),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tkeep      (m_axis_tkeep),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tuser_err  (m_axis_tuser_err),
      .m_axis_tready     (m_axis_tready),
      .src_en            (src_en),
      .grant             (grant)
`ifdef P2P_TX_ARB_STATS_EN
      ,
      .pkt_cnt0          (pkt_cnt0),
      .pkt_cnt1          (pkt_cnt1),
      .cnt_clr           (cnt_clr)
`endif
   );

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void drive_srcs();
      beat_t z;
      z = '0;
      if (q0.size() > 0) z = q0[0];
      s0_axis_tvalid    = (q0.size() > 0);
      s0_axis_tdata     = z.data;
      s0_axis_tkeep     = z.keep;
      s0_axis_tlast     = z.last;
      s0_axis_tuser_err = z.err;
      z = '0;
      if (q1.size() > 0) z = q1[0];
      s1_axis_tvalid    = (q1.size() > 0);
      s1_axis_tdata     = z.data;
      s1_axis_tkeep     = z.keep;
      s1_axis_tlast     = z.last;
      s1_axis_tuser_err = z.err;
   endfunction

   task automatic add_pkt(input logic src, input int len, input logic [31:0] tag,
                          input logic err, input bit to_src, input bit to_exp);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {16{tag + 32'(k)}};
         b.keep = (k == len - 1) ? 64'h0000_0000_0000_FFFF : '1;
         b.last = (k == len - 1);
         b.err  = err;
         b.src  = src;
         if (to_src) begin
            if (src) q1.push_back(b);
            else     q0.push_back(b);
         end
         if (to_exp) expq.push_back(b);
      end
      drive_srcs();
   endtask

   // One clock: sample outputs at the falling edge, then update the sources after the rising edge.
   task automatic cycle();
      beat_t e;
      logic  x0, x1;
      @(negedge cmac_clk);
      smp_valid = m_axis_tvalid;
      x0 = s0_axis_tvalid & s0_axis_tready;
      x1 = s1_axis_tvalid & s1_axis_tready;
      if (m_axis_tvalid) begin
         if (expq.size() == 0) begin
            chk("unexpected_beat", 512'(m_axis_tdata), 512'd0);
         end else begin
            e = expq[0];
            chk("tdata", m_axis_tdata, e.data);
            chk("tkeep", 512'(m_axis_tkeep), 512'(e.keep));
            chk("tlast_err", 512'({m_axis_tlast, m_axis_tuser_err}), 512'({e.last, e.err}));
            chk("grant_owner", 512'(grant), e.src ? 512'd2 : 512'd1);
            chk("tready_mirror", 512'({s1_axis_tready, s0_axis_tready}),
                e.src ? 512'({m_axis_tready, 1'b0}) : 512'({1'b0, m_axis_tready}));
            if (m_axis_tready) begin
               void'(expq.pop_front());
               in_pkt = !e.last;
`ifdef P2P_TX_ARB_STATS_EN
               if (e.last && e.src)  cnt1_m = cnt1_m + 32'd1;
               if (e.last && !e.src) cnt0_m = cnt0_m + 32'd1;
`endif
            end
         end
      end else begin
         chk("idle_outputs", 512'({grant, s1_axis_tready, s0_axis_tready, m_axis_tlast, m_axis_tuser_err}), 512'd0);
         chk("idle_tdata", m_axis_tdata, 512'd0);
         chk("packet_gap", 512'(in_pkt), 512'd0);
      end
`ifdef P2P_TX_ARB_STATS_EN
      if (cnt_clr) begin
         cnt0_m = '0;
         cnt1_m = '0;
      end
`endif
      @(posedge cmac_clk);
      #1;
      if (x0) void'(q0.pop_front());
      if (x1) void'(q1.pop_front());
      drive_srcs();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (expq.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 512'(expq.size()), 512'd0);
   endtask

   initial begin
      int rp [6];
      rp = '{1, 1, 0, 0, 1, 1};
      mod_rstn      = 1'b0;
      m_axis_tready = 1'b1;
      src_en        = 2'b11;
`ifdef P2P_TX_ARB_STATS_EN
      cnt_clr = 1'b0;
      cnt0_m  = '0;
      cnt1_m  = '0;
`endif
      // Reset held with both sources valid: nothing may be granted.
      add_pkt(1'b0, 1, 32'h0C00_0000, 1'b0, 1, 1);
      add_pkt(1'b1, 1, 32'h0D00_0000, 1'b1, 1, 1);
      repeat (3) @(posedge cmac_clk);
      @(negedge cmac_clk);
      chk("rst_grant", 512'(grant), 512'd0);
      chk("rst_ctrl", 512'({m_axis_tvalid, s1_axis_tready, s0_axis_tready}), 512'd0);
      chk("rst_tdata", m_axis_tdata, 512'd0);
      @(posedge cmac_clk);
      #1;
      mod_rstn = 1'b1;
      cycle();
      chk("first_grant", 512'(grant), 512'd1);
      drain(20);

      // Contention with 1-beat packets: A,B alternate with one idle cycle each.
      for (int n = 0; n < 4; n++) begin
         add_pkt(1'b0, 1, 32'hA000_0000 + 32'(n << 8), 1'b0, 1, 1);
         add_pkt(1'b1, 1, 32'hB000_0000 + 32'(n << 8), 1'(n & 1), 1, 1);
      end
      for (int i = 0; i < 16; i++) begin
         cycle();
         chk("bubble_pattern", 512'(smp_valid), 512'(i % 2));
      end
      chk("contention_done", 512'(expq.size()), 512'd0);

      // Atomicity: source 0 keeps the link after src_en[0] drops mid-packet.
      add_pkt(1'b0, 4, 32'h5000_0000, 1'b1, 1, 1);
      add_pkt(1'b0, 2, 32'h5100_0000, 1'b0, 1, 0);
      cycle();
      add_pkt(1'b1, 1, 32'h6000_0000, 1'b0, 1, 1);
      cycle();
      src_en = 2'b10;
      drain(20);

      // Disabled source 0 stays pending while source 1 traffic flows.
      add_pkt(1'b1, 2, 32'h6100_0000, 1'b0, 1, 1);
      add_pkt(1'b1, 1, 32'h6200_0000, 1'b1, 1, 1);
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("s0_tready_blocked", 512'(s0_axis_tready), 512'd0);
      end
      chk("disable_done", 512'(expq.size()), 512'd0);
      src_en = 2'b11;
      add_pkt(1'b0, 2, 32'h5100_0000, 1'b0, 0, 1);
      drain(20);

      // Backpressure during a 3-beat packet.
      add_pkt(1'b1, 3, 32'h7000_0000, 1'b0, 1, 1);
      for (int i = 0; i < 6; i++) begin
         m_axis_tready = 1'(rp[i]);
         cycle();
      end
      m_axis_tready = 1'b1;
      chk("backpressure_done", 512'(expq.size()), 512'd0);

`ifdef P2P_TX_ARB_STATS_EN
      chk("cnt0_model", 512'(pkt_cnt0), 512'(cnt0_m));
      chk("cnt1_model", 512'(pkt_cnt1), 512'(cnt1_m));
      force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt0_q;
      cnt0_m = 32'hFFFF_FFFF;
      add_pkt(1'b0, 1, 32'h8000_0000, 1'b0, 1, 1);
      drain(10);
      chk("cnt0_wrap", 512'(pkt_cnt0), 512'd0);
      add_pkt(1'b1, 1, 32'h9000_0000, 1'b0, 1, 1);
      cycle();
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("cnt1_clear_wins", 512'(pkt_cnt1), 512'd0);
      chk("cnt1_model_end", 512'(pkt_cnt1), 512'(cnt1_m));
`endif

      repeat (2) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
